// File: rtl/cphy_lp_pkg.sv
// cphy_lp_pkg: shared LP line states, escape command codes and receiver FSM states
package cphy_lp_pkg;
   localparam logic [2:0] LP_111 = 3'b111;
   localparam logic [2:0] LP_100 = 3'b100;
   localparam logic [2:0] LP_000 = 3'b000;
   localparam logic [2:0] LP_001 = 3'b001;
   localparam logic [7:0] CMD_LPDT = 8'hE1;
   localparam logic [7:0] CMD_ULPS = 8'h1E;
   localparam logic [7:0] CMD_TRIG [4] = '{8'h62, 8'h5D, 8'h21, 8'hA0};
   typedef enum logic [3:0] {
      WAIT_STOP, STOP, RQST, BRIDGE, ESC_RQST, CMD, LPDT, ULPS, WAIT_EXIT
   } lpState_t;
endpackage

// File: rtl/cphy_lp_line_filter.sv
// cphy_lp_line_filter: per-line synchroniser plus run-length glitch filter for the LP bus
module cphy_lp_line_filter #(
   parameter int WIDTH = 3,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] filt
);
   localparam int CW = $clog2(FILT_CYC + 1);
   logic [WIDTH-1:0] syncQ [SYNC_STAGES];
   logic [WIDTH-1:0] sample, cand;
   logic [CW-1:0] runCnt;
   logic [CW:0] runNext;
   logic accept;
   assign sample = syncQ[SYNC_STAGES-1];
   // runCnt is the length of the current run of a value that differs from filt
   assign runNext = (sample == cand) ? {1'b0, runCnt} + (CW+1)'(1) : (CW+1)'(1);
   assign accept = sample != filt && runNext >= (CW+1)'(FILT_CYC);
   always_ff @(posedge CLK) begin
      if (RST) begin
         syncQ <= '{default: '1};
         cand <= '1;
         runCnt <= '0;
         filt <= '1;
      end else begin
         syncQ[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
         cand <= sample;
         filt <= accept ? sample : filt;
         runCnt <= (sample == filt || accept) ? '0 : runNext[CW-1:0];
      end
   end
endmodule

// File: rtl/cphy_lp_escape_rx.sv
// cphy_lp_escape_rx: C-PHY LP escape receiver (entry, command, LPDT FIFO, errors); CPHY_ESC_TIMEOUT_EN adds an inactivity timeout
module cphy_lp_escape_rx
   import cphy_lp_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         A,
   input  logic                         B,
   input  logic                         C,
   input  logic                         EscDecoderEn,
   output logic                         RxLpdtEsc,
   output logic                         RxUlpsEsc,
   output logic [3:0]                   RxTriggerEsc,
   output logic [7:0]                   RxDataEsc,
   output logic                         RxValidEsc,
   input  logic                         RxReadyEsc,
   output logic                         ErrEsc,
   output logic                         ErrSyncEsc,
   output logic                         ErrControl,
   output logic                         ErrOverflow,
   output logic                         LpFsmStop,
   output logic [$clog2(FIFO_DEPTH):0]  FifoLevel
);
   localparam int AW = $clog2(FIFO_DEPTH);
   lpState_t st, stNext;
   logic [2:0] lpCur, lpPrev, bitCnt, bitNext;
   logic [7:0] shReg, shNext, cmdNext, pushData, pushDataNext;
   logic [3:0] trigHit, trigNext;
   logic chg, bitOne, bitZero, mark, exitEv, ctlErr, clrErr, timeout;
   logic lpdtNext, ulpsNext, errEscNext, errSyncNext, errCtlNext, pushReq, pushNext;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic full, pop, wrEn;

   cphy_lp_line_filter #(.WIDTH(3), .SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) lineFilter (
      .CLK(CLK), .RST(RST), .raw({A, B, C}), .filt(lpCur)
   );

   assign chg = lpCur != lpPrev;
   assign bitOne = lpPrev == LP_100 && lpCur == LP_000;
   assign bitZero = lpPrev == LP_001 && lpCur == LP_000;
   assign mark = lpPrev == LP_000 && (lpCur == LP_100 || lpCur == LP_001);
   assign exitEv = lpPrev == LP_100 && lpCur == LP_111;
   assign cmdNext = {shReg[6:0], bitOne};
   assign LpFsmStop = st == STOP;
   for (genvar i = 0; i < 4; i++) begin : gTrig
      assign trigHit[i] = cmdNext == CMD_TRIG[i];
   end

`ifdef CPHY_ESC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] idleCnt;
   logic exempt;
   assign exempt = st inside {WAIT_STOP, STOP, ULPS};
   always_ff @(posedge CLK) idleCnt <= (RST || chg || exempt) ? '0 : idleCnt + TW'(1);
   assign timeout = !exempt && !chg && idleCnt == TW'(TIMEOUT_CYC - 1);
`else
   // no inactivity limit in this build; TIMEOUT_CYC is kept only so both builds share one interface
   assign timeout = TIMEOUT_CYC < 0;
`endif

   always_comb begin
      stNext = st;
      shNext = shReg;
      bitNext = bitCnt;
      lpdtNext = RxLpdtEsc;
      ulpsNext = RxUlpsEsc;
      trigNext = '0;
      errEscNext = ErrEsc;
      errSyncNext = ErrSyncEsc;
      errCtlNext = ErrControl;
      pushNext = 1'b0;
      pushDataNext = pushData;
      ctlErr = 1'b0;
      clrErr = 1'b0;
      case (st)
         WAIT_STOP: stNext = lpCur == LP_111 ? STOP : WAIT_STOP;
         STOP: if (chg) stNext = lpCur == LP_100 ? RQST : WAIT_STOP;
         RQST: if (chg) begin
            stNext = BRIDGE;
            ctlErr = lpCur != LP_000;
         end
         BRIDGE: if (chg) begin
            stNext = ESC_RQST;
            ctlErr = lpCur != LP_001;
         end
         ESC_RQST: if (chg) begin
            stNext = CMD;
            bitNext = 3'd0;
            ctlErr = lpCur != LP_000;
            clrErr = !ctlErr;
            if (clrErr) begin
               errEscNext = 1'b0;
               errSyncNext = 1'b0;
               errCtlNext = 1'b0;
            end
         end
         CMD, LPDT: if (chg) begin
            ctlErr = !(exitEv || bitOne || bitZero || mark);
            if (bitOne || bitZero) begin
               bitNext = bitCnt + 3'd1;
               if (st == CMD) begin
                  shNext = cmdNext;
                  if (bitCnt == 3'd7) begin
                     trigNext = trigHit;
                     lpdtNext = cmdNext == CMD_LPDT;
                     ulpsNext = cmdNext == CMD_ULPS;
                     errEscNext = ErrEsc | !(lpdtNext | ulpsNext | (|trigHit));
                     stNext = lpdtNext ? LPDT : ulpsNext ? ULPS : WAIT_EXIT;
                  end
               end else begin
                  shNext = {bitOne, shReg[7:1]};
                  pushNext = bitCnt == 3'd7;
                  pushDataNext = shNext;
               end
            end
         end
         default: ;
      endcase
      if (exitEv && st inside {CMD, LPDT, ULPS, WAIT_EXIT}) begin
         stNext = STOP;
         lpdtNext = 1'b0;
         ulpsNext = 1'b0;
         errSyncNext = ErrSyncEsc | (bitCnt != 3'd0);
      end
      if (ctlErr || timeout) begin
         stNext = WAIT_STOP;
         lpdtNext = 1'b0;
         ulpsNext = 1'b0;
         errCtlNext = 1'b1;
      end
      if (!EscDecoderEn) begin
         stNext = WAIT_STOP;
         lpdtNext = 1'b0;
         ulpsNext = 1'b0;
         trigNext = '0;
         pushNext = 1'b0;
         clrErr = 1'b0;
         errEscNext = ErrEsc;
         errSyncNext = ErrSyncEsc;
         errCtlNext = ErrControl;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         st <= WAIT_STOP;
         lpPrev <= LP_111;
         shReg <= '0;
         bitCnt <= '0;
         RxLpdtEsc <= 1'b0;
         RxUlpsEsc <= 1'b0;
         RxTriggerEsc <= '0;
         ErrEsc <= 1'b0;
         ErrSyncEsc <= 1'b0;
         ErrControl <= 1'b0;
         pushReq <= 1'b0;
         pushData <= '0;
      end else begin
         st <= stNext;
         lpPrev <= lpCur;
         shReg <= shNext;
         bitCnt <= bitNext;
         RxLpdtEsc <= lpdtNext;
         RxUlpsEsc <= ulpsNext;
         RxTriggerEsc <= trigNext;
         ErrEsc <= errEscNext;
         ErrSyncEsc <= errSyncNext;
         ErrControl <= errCtlNext;
         pushReq <= pushNext;
         pushData <= pushDataNext;
      end
   end

   assign full = FifoLevel == (AW+1)'(FIFO_DEPTH);
   assign RxValidEsc = FifoLevel != '0;
   assign pop = RxValidEsc && RxReadyEsc;
   // a full FIFO still takes a byte when the head is popped in the same cycle
   assign wrEn = pushReq && (!full || pop);
   assign RxDataEsc = RxValidEsc ? mem[rdPtr] : 8'h00;

   always_ff @(posedge CLK) if (wrEn) mem[wrPtr] <= pushData;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr <= '0;
         rdPtr <= '0;
         FifoLevel <= '0;
         ErrOverflow <= 1'b0;
      end else begin
         wrPtr <= wrPtr + AW'(wrEn);
         rdPtr <= rdPtr + AW'(pop);
         FifoLevel <= FifoLevel + (AW+1)'(wrEn) - (AW+1)'(pop);
         ErrOverflow <= !clrErr && (ErrOverflow || (pushReq && !wrEn));
      end
   end
endmodule

// File: tb/tb_cphy_lp_escape_rx.sv
// tb_cphy_lp_escape_rx: directed and randomized escape traffic checked against a transaction-level model
`timescale 1ns/1ps
module tb_cphy_lp_escape_rx;
   localparam int DEPTH = 4;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1, ready = 1'b0;
   logic [2:0] lp = 3'b111;
   logic lpdt, ulps, valid, errEsc, errSync, errCtl, errOvf, stop;
   logic [3:0] trig;
   logic [7:0] data;
   logic [2:0] level;
   int nChecks = 0, nFails = 0;
   int trigCycles = 0;
   logic [3:0] trigSeen = 4'h0;
   int holdMin = 10, holdMax = 10;
   logic [7:0] expQ [$];
   logic [7:0] txBytes [$];
   logic expOvf = 1'b0;
   logic [7:0] cmdList [6] = '{8'hE1, 8'h1E, 8'h62, 8'h5D, 8'h21, 8'hA0};

   always #5 clk = ~clk;

   cphy_lp_escape_rx dut (
      .CLK(clk), .RST(rst), .A(lp[2]), .B(lp[1]), .C(lp[0]), .EscDecoderEn(en),
      .RxLpdtEsc(lpdt), .RxUlpsEsc(ulps), .RxTriggerEsc(trig), .RxDataEsc(data),
      .RxValidEsc(valid), .RxReadyEsc(ready), .ErrEsc(errEsc), .ErrSyncEsc(errSync),
      .ErrControl(errCtl), .ErrOverflow(errOvf), .LpFsmStop(stop), .FifoLevel(level)
   );

   always @(negedge clk) if (trig != 4'h0) begin
      trigCycles++;
      trigSeen = trig;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] expTrig(input logic [7:0] c);
      return c == 8'h62 ? 4'b0001 : c == 8'h5D ? 4'b0010 : c == 8'h21 ? 4'b0100 : c == 8'hA0 ? 4'b1000 : 4'b0000;
   endfunction

   function automatic int hl();
      return int'($urandom_range(holdMax, holdMin));
   endfunction

   task automatic hold(input logic [2:0] s, input int n);
      lp = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic entry();
      expOvf = 1'b0;
      hold(3'b111, 10);
      hold(3'b100, hl());
      hold(3'b000, hl());
      hold(3'b001, hl());
      hold(3'b000, hl());
   endtask

   task automatic sendBit(input logic b);
      hold(b ? 3'b100 : 3'b001, hl());
      hold(3'b000, hl());
   endtask

   task automatic sendCmd(input logic [7:0] c);
      for (int i = 7; i >= 0; i--) sendBit(c[i]);
   endtask

   task automatic sendData(input logic [7:0] d);
      for (int i = 0; i < 8; i++) sendBit(d[i]);
      if (expQ.size() < DEPTH) expQ.push_back(d);
      else expOvf = 1'b1;
   endtask

   task automatic sendExit();
      hold(3'b100, hl());
      hold(3'b111, 10);
   endtask

   task automatic drain(input string tag);
      for (int g = 0; g < 40 && expQ.size() != 0; g++) begin
         @(negedge clk);
         if (valid) begin
            chk({tag, "_data"}, data, expQ.pop_front());
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
         end
      end
      chk({tag, "_drained"}, {expQ.size() != 0, level}, 0);
   endtask

   task automatic lpdtRun(input string tag, input int partial, input logic glitch);
      entry();
      sendCmd(8'hE1);
      settle();
      chk({tag, "_mode"}, {lpdt, ulps}, 2'b10);
      if (glitch) begin
         hold(3'b100, 2);
         hold(3'b000, hl());
      end
      foreach (txBytes[i]) sendData(txBytes[i]);
      for (int i = 0; i < partial; i++) sendBit(1'($urandom_range(1, 0)));
      settle();
      chk({tag, "_level"}, level, expQ.size());
      chk({tag, "_ovf"}, errOvf, expOvf);
      sendExit();
      chk({tag, "_exit"}, {stop, lpdt, ulps, errCtl}, 4'b1000);
      chk({tag, "_sync"}, errSync, partial != 0);
      drain(tag);
      txBytes.delete();
   endtask

   task automatic cmdRun(input string tag, input logic [7:0] c);
      logic [3:0] et;
      logic known;
      int lost;
      et = expTrig(c);
      known = c == 8'hE1 || c == 8'h1E || et != 4'h0;
      lost = 0;
      trigCycles = 0;
      trigSeen = 4'h0;
      entry();
      sendCmd(c);
      settle();
      chk({tag, "_mode"}, {lpdt, ulps}, {c == 8'hE1, c == 8'h1E});
      chk({tag, "_errEsc"}, errEsc, !known);
      if (c == 8'h1E) begin
         repeat (200) begin
            @(negedge clk);
            if (!ulps) lost++;
         end
         chk({tag, "_ulpsHeld"}, lost, 0);
      end
      sendExit();
      chk({tag, "_trigN"}, trigCycles, et != 4'h0);
      chk({tag, "_trig"}, trigSeen, et);
      chk({tag, "_exit"}, {stop, lpdt, ulps, errSync, errCtl}, 5'b10000);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {stop, valid, level, data, lpdt, ulps, trig}, 0);
      chk("rst_err", {errEsc, errSync, errCtl, errOvf}, 0);
      rst = 1'b0;
      settle();
      chk("idle_stop", stop, 1);

      txBytes = '{8'hA5, 8'h3C};
      lpdtRun("lpdt2", 0, 1'b0);
      cmdRun("ulps", 8'h1E);
      cmdRun("trig62", 8'h62);
      cmdRun("trigA0", 8'hA0);
      cmdRun("bad63", 8'h63);
      entry();
      settle();
      chk("clr_errEsc", errEsc, 0);
      sendExit();
      lpdtRun("sync7", 7, 1'b0);

      hold(3'b111, 10);
      hold(3'b100, 10);
      hold(3'b111, 10);
      settle();
      chk("ctl_rqst", {errCtl, stop}, 2'b11);

      txBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      lpdtRun("ovf", 0, 1'b1);

      entry();
      sendCmd(8'hE1);
      settle();
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("en_low", {stop, lpdt, ulps, errCtl, errEsc, errSync}, 0);
      hold(3'b111, 10);
      en = 1'b1;
      settle();
      chk("en_back", stop, 1);

      entry();
      sendCmd(8'hE1);
      sendData(8'h5A);
      settle();
      chk("mid_level", level, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst", {stop, lpdt, level}, 0);
      lp = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      settle();
      chk("mid_after", {stop, valid}, 2'b10);

      holdMin = 6;
      holdMax = 12;
      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(1, 0) == 0) begin
            for (int k = int'($urandom_range(5, 0)); k > 0; k--) txBytes.push_back(8'($urandom));
            lpdtRun("rndLpdt", $urandom_range(1, 0) == 0 ? 0 : int'($urandom_range(7, 1)), 1'($urandom_range(1, 0)));
         end else begin
            int idx;
            idx = int'($urandom_range(6, 0));
            cmdRun("rndCmd", idx == 6 ? 8'($urandom) : cmdList[idx]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
